// File: rtl/rr_req_arbiter_pkg.sv
// Shared types and default sizing for the round-robin request arbiter.
// Holds the two-state FSM enum and the default requester count / tenure.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int NUM_REQ_DEF  = 4;
   localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_req_arbiter_pick.sv
// rr_pick: combinational rotate-priority selector.
// Ports: i_req (requests), i_ptr (highest-priority index),
//        o_sel (chosen index), o_sel_valid (any request present).
module rr_pick
   import arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [ID_W-1:0]    o_sel,
   output logic               o_sel_valid
);

   logic [ID_W-1:0] w_idx;

   // Walk offsets from the far end back to offset 0 so the
   // last hit (smallest offset from the pointer) wins.
   always_comb begin
      o_sel       = '0;
      o_sel_valid = 1'b0;
      w_idx       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
         if (i_req[w_idx]) begin
            o_sel       = w_idx;
            o_sel_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter with bounded grant tenure.
// Ports: clk, rst (sync, active-high), req/done (per requester),
//        gnt, gnt_valid, gnt_id, any_req, timeout (all registered).
module rr_req_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int ID_W     = $clog2(NUM_REQ),
   parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic               any_req,
   output logic               timeout
);

   state_t             r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_gv;
   logic [ID_W-1:0]    r_id;
   logic [ID_W-1:0]    r_ptr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_any;
   logic               r_to;

   state_t             w_state_nxt;
   logic [NUM_REQ-1:0] w_gnt_nxt;
   logic [ID_W-1:0]    w_id_nxt;
   logic [ID_W-1:0]    w_ptr_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_to_nxt;
   logic [ID_W-1:0]    w_sel;
   logic               w_sel_valid;
   logic               w_rel_done;
   logic               w_rel_drop;
   logic               w_rel_max;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .i_req       (req),
      .i_ptr       (r_ptr),
      .o_sel       (w_sel),
      .o_sel_valid (w_sel_valid)
   );

   assign w_rel_done = done[r_id];
   assign w_rel_drop = ~req[r_id];
   assign w_rel_max  = (r_cnt == CNT_W'(MAX_HOLD));

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_id_nxt    = r_id;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_to_nxt    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_sel_valid) begin
               w_gnt_nxt        = '0;
               w_gnt_nxt[w_sel] = 1'b1;
               w_id_nxt         = w_sel;
               w_cnt_nxt        = CNT_W'(1);
               w_state_nxt      = GRANT;
               // Winner drops to lowest priority next round.
               if (w_sel == ID_W'(NUM_REQ - 1)) begin
                  w_ptr_nxt = '0;
               end else begin
                  w_ptr_nxt = w_sel + ID_W'(1);
               end
            end
         end
         GRANT: begin
            if (w_rel_done || w_rel_drop || w_rel_max) begin
               w_gnt_nxt   = '0;
               w_state_nxt = IDLE;
               // Flag only revocations the requester did not ask for.
               w_to_nxt    = w_rel_max & ~w_rel_done & ~w_rel_drop;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_gv    <= 1'b0;
         r_id    <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_any   <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_gv    <= |w_gnt_nxt;
         r_id    <= w_id_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_any   <= |req;
         r_to    <= w_to_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_valid = r_gv;
   assign gnt_id    = r_id;
   assign any_req   = r_any;
   assign timeout   = r_to;

endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
Round-robin arbiter for four request lines (A, B, C, D) that today are only OR-combined and registered into a single "something is requesting" flag. It keeps that registered any-request flag and grants the shared resource to one requester at a time. Grant tenure is bounded, so no requester can starve the others. It sits between the requesters and the shared downstream resource.

Parameters:
NUM_REQ, 4, number of requesters; each requester has one bit in req, done and gnt.
MAX_HOLD, 8, maximum grant tenure in cycles; must be >= 1.
ID_W, $clog2(NUM_REQ), width of gnt_id.
CNT_W, $clog2(MAX_HOLD+1), width of the internal tenure counter.

Ports:
clk  input  1  single clock; all logic on posedge clk.
rst  input  1  synchronous, active-high reset.
req  input  NUM_REQ  level request per requester; held high while it wants the resource.
done  input  NUM_REQ  1-cycle pulse from the granted requester ending its tenure; ignored on non-granted bits.
gnt  output  NUM_REQ  registered one-hot grant; all-zero when no grant is active.
gnt_valid  output  1  registered; equals OR of gnt.
gnt_id  output  ID_W  registered index of the granted requester; holds its last value when gnt_valid=0.
any_req  output  1  registered OR of all req bits; 1-cycle latency.
timeout  output  1  registered 1-cycle pulse when a grant is revoked because MAX_HOLD was reached.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, any_req=0, timeout=0, FSM=IDLE, priority pointer=0, tenure counter=0.
- Reset asserted mid-grant clears everything on the next edge. No grant survives reset.
- any_req: any_req <= |req every cycle, independent of the FSM.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If |req=1, select the first set req bit, searching upward from the pointer and wrapping from NUM_REQ-1 to 0.
  - On the next edge: gnt <= one-hot(sel), gnt_id <= sel, pointer <= (sel+1) mod NUM_REQ, counter <= 1, go to GRANT.
  - If |req=0, stay in IDLE.
- GRANT: with g=gnt_id, release when any of the following holds (priority order):
  - (a) done[g]=1;
  - (b) req[g]=0;
  - (c) counter==MAX_HOLD.
- On release: gnt <= 0, go to IDLE.
  - timeout <= 1 only for case (c) with neither (a) nor (b) true in the same cycle; otherwise timeout=0.
- Without release: counter <= counter+1, gnt is held.
- Grant tenure is therefore at most MAX_HOLD cycles.
- Every release is followed by exactly one cycle with gnt=0 before the next grant. This gap is mandatory, including when the releasing requester is the only one requesting.
- Latency: req rising while in IDLE gives gnt high on the next edge (1 cycle).
- The pointer advances only when a grant is issued, never on release.
- After requester i is granted, it has the lowest priority in the next arbitration.
- done pulses on non-granted bits, and done while in IDLE, have no effect.
- Simultaneous requests are resolved purely by pointer order.
- No combinational path from inputs to any output.

Decomposition:
- Shared package arb_pkg holds:
  - state enum {IDLE, GRANT};
  - default constants NUM_REQ=4, MAX_HOLD=8.
- One sub-module, rr_pick:
  - purely combinational rotate-priority selector;
  - inputs req and pointer; outputs sel index and sel_valid.
  - It is unit-testable on its own.
- The top level holds the FSM, the tenure counter, the pointer and the any_req register.

Test Plan:
1. Reset priority: rst for 2 cycles; then req=4'b1111 held, done pulsed on the granted bit one cycle after each grant.
   - Grants in order 0,1,2,3,0, each separated by one gnt=0 cycle.
   - any_req=1 one cycle after req is applied.
2. Timeout: req=4'b0100 held, no done.
   - gnt=4'b0100 for exactly 8 cycles, then timeout=1 for one cycle with gnt=0.
   - Re-grant to 2 the following cycle; this repeats.
3. Request drop: grant to 1 with req=4'b0010, then req=4'b0000 on the 3rd grant cycle.
   - gnt=0 on the next edge, timeout=0.
   - any_req falls one cycle after req drops.
4. Simultaneous events: on the 8th tenure cycle (counter==MAX_HOLD), assert done on the granted bit.
   - Grant released and timeout stays 0.
   - A done pulse on a non-granted bit in a prior cycle has no effect.
5. Reset mid-grant: rst pulsed while gnt=4'b1000.
   - Next edge: gnt=0, pointer=0.
   - With req=4'b1001 after reset, the first grant goes to 0, not 3.
6. Wrap-around: pointer=3 (after a grant to 2), req=4'b0011.
   - Grant goes to 0, then to 1, demonstrating the pointer wrapping from 3 to 0.
